// File: rtl/video_scale_pkg.sv
// Shared types and constants for the downscaler frame controller.
package video_scale_pkg;
  localparam int FRAC_BITS = 16;
  localparam int RES_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DIV_X,
    ST_DIV_Y,
    ST_SYNC
  } vsc_state_t;
endpackage

// File: rtl/serial_div_u32_u16.sv
// Restoring divider, one quotient bit per cycle. The start cycle already
// resolves the first bit, so o_done is high exactly DIV_W cycles after start.
module serial_div_u32_u16
  import video_scale_pkg::*;
#(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [DIV_W-1:0] i_dividend,
  input  logic [RES_W-1:0] i_divisor,
  output logic             o_done,
  output logic [DIV_W-1:0] o_quotient
);
  localparam int CNT_W = $clog2(DIV_W) + 1;

  logic [RES_W-1:0] r_rem;
  logic [DIV_W-1:0] r_quo;
  logic [RES_W-1:0] r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  // Remainder always stays below the divisor, so it fits in RES_W bits.
  function automatic logic [RES_W+DIV_W-1:0] div_step(
    input logic [RES_W-1:0] rem,
    input logic [DIV_W-1:0] quo,
    input logic [RES_W-1:0] dvs
  );
    logic [RES_W:0] w_shift;
    logic [RES_W:0] w_trial;
    w_shift = {rem, quo[DIV_W-1]};
    w_trial = w_shift - {1'b0, dvs};
    if (w_shift >= {1'b0, dvs})
      return {w_trial[RES_W-1:0], quo[DIV_W-2:0], 1'b1};
    else
      return {w_shift[RES_W-1:0], quo[DIV_W-2:0], 1'b0};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        {r_rem, r_quo} <= div_step('0, i_dividend, i_divisor);
        r_dvs  <= i_divisor;
        r_cnt  <= CNT_W'(1);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        {r_rem, r_quo} <= div_step(r_rem, r_quo, r_dvs);
        r_cnt <= r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(DIV_W - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done     = r_done;
  assign o_quotient = r_quo;
endmodule

// File: rtl/video_scale_ctrl.sv
// Frame-level controller for the nearest-neighbour downscaler.
// Optional build macro SCALE_CLAMP_EN clamps requested outputs to the input size.
module video_scale_ctrl
  import video_scale_pkg::*;
#(
  parameter int DIV_W = 32
) (
  input  logic             vin_clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [RES_W-1:0] cfg_vin_xres,
  input  logic [RES_W-1:0] cfg_vin_yres,
  input  logic [RES_W-1:0] cfg_vout_xres,
  input  logic [RES_W-1:0] cfg_vout_yres,
  output logic             cfg_err,
  output logic             frame_sync,
  output logic [RES_W-1:0] vin_xres,
  output logic [RES_W-1:0] vin_yres,
  output logic [RES_W-1:0] vout_xres,
  output logic [RES_W-1:0] vout_yres,
  output logic [DIV_W-1:0] scaler_width,
  output logic [DIV_W-1:0] scaler_height,
  output logic             coeff_valid,
  output logic             ready_gate,
  output logic             frame_miss
);
  vsc_state_t       r_state;
  logic             r_pending;
  logic [RES_W-1:0] r_sh_vin_x, r_sh_vin_y, r_sh_vout_x, r_sh_vout_y;
  logic [RES_W-1:0] r_wk_vin_x, r_wk_vin_y, r_wk_vout_x, r_wk_vout_y;
  logic [DIV_W-1:0] r_coef_x;

  logic             w_cfg_fire;
  logic             w_cfg_bad;
  logic [RES_W-1:0] w_vout_x, w_vout_y;
  logic             w_div_start;
  logic             w_div_done;
  logic [DIV_W-1:0] w_dividend;
  logic [RES_W-1:0] w_divisor;
  logic [DIV_W-1:0] w_div_quo;

  assign cfg_ready  = !r_pending;
  assign w_cfg_fire = cfg_valid && cfg_ready;
  assign w_cfg_bad  = (cfg_vout_xres == '0) || (cfg_vout_yres == '0);

`ifdef SCALE_CLAMP_EN
  assign w_vout_x = (cfg_vout_xres > cfg_vin_xres) ? cfg_vin_xres : cfg_vout_xres;
  assign w_vout_y = (cfg_vout_yres > cfg_vin_yres) ? cfg_vin_yres : cfg_vout_yres;
`else
  assign w_vout_x = cfg_vout_xres;
  assign w_vout_y = cfg_vout_yres;
`endif

  // X division reads the shadow directly while LOAD copies it; Y follows X back-to-back.
  assign w_div_start = (r_state == ST_LOAD) || ((r_state == ST_DIV_X) && w_div_done);
  assign w_dividend  = (r_state == ST_LOAD) ? DIV_W'({r_sh_vin_x, {FRAC_BITS{1'b0}}})
                                            : DIV_W'({r_wk_vin_y, {FRAC_BITS{1'b0}}});
  assign w_divisor   = (r_state == ST_LOAD) ? r_sh_vout_x : r_wk_vout_y;

  serial_div_u32_u16 #(.DIV_W(DIV_W)) u_div (
    .clk       (vin_clk),
    .rst_n     (rst_n),
    .i_start   (w_div_start),
    .i_dividend(w_dividend),
    .i_divisor (w_divisor),
    .o_done    (w_div_done),
    .o_quotient(w_div_quo)
  );

  always_ff @(posedge vin_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= w_cfg_fire && w_cfg_bad;
      if (w_cfg_fire && !w_cfg_bad)
        r_pending <= 1'b1;
      else if (r_state == ST_LOAD)
        r_pending <= 1'b0;
    end
  end

  always_ff @(posedge vin_clk) begin
    if (w_cfg_fire && !w_cfg_bad) begin
      r_sh_vin_x  <= cfg_vin_xres;
      r_sh_vin_y  <= cfg_vin_yres;
      r_sh_vout_x <= w_vout_x;
      r_sh_vout_y <= w_vout_y;
    end
    if (r_state == ST_LOAD) begin
      r_wk_vin_x  <= r_sh_vin_x;
      r_wk_vin_y  <= r_sh_vin_y;
      r_wk_vout_x <= r_sh_vout_x;
      r_wk_vout_y <= r_sh_vout_y;
    end
    if ((r_state == ST_DIV_X) && w_div_done)
      r_coef_x <= w_div_quo + DIV_W'(1);
  end

  always_ff @(posedge vin_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      frame_sync    <= 1'b0;
      vin_xres      <= '0;
      vin_yres      <= '0;
      vout_xres     <= '0;
      vout_yres     <= '0;
      scaler_width  <= '0;
      scaler_height <= '0;
      coeff_valid   <= 1'b0;
      ready_gate    <= 1'b0;
      frame_miss    <= 1'b0;
    end else begin
      if (frame_start && (r_state != ST_IDLE))
        frame_miss <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (frame_start) begin
            ready_gate <= 1'b0;
            if (r_pending) begin
              r_state <= ST_LOAD;
            end else begin
              r_state    <= ST_SYNC;
              frame_sync <= 1'b1;
            end
          end else begin
            ready_gate <= coeff_valid;
          end
        end
        ST_LOAD: r_state <= ST_DIV_X;
        ST_DIV_X: if (w_div_done) r_state <= ST_DIV_Y;
        ST_DIV_Y: begin
          // Everything the scaler sees changes together with the sync pulse.
          if (w_div_done) begin
            r_state       <= ST_SYNC;
            frame_sync    <= 1'b1;
            vin_xres      <= r_wk_vin_x;
            vin_yres      <= r_wk_vin_y;
            vout_xres     <= r_wk_vout_x;
            vout_yres     <= r_wk_vout_y;
            scaler_width  <= r_coef_x;
            scaler_height <= w_div_quo + DIV_W'(1);
            coeff_valid   <= 1'b1;
          end
        end
        ST_SYNC: begin
          r_state    <= ST_IDLE;
          frame_sync <= 1'b0;
          ready_gate <= coeff_valid;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_video_scale_ctrl.sv
// Self-checking bench for video_scale_ctrl: table vectors, corner sequences, random frames.
module tb_video_scale_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [15:0] cvx = '0, cvy = '0, cox = '0, coy = '0;
  logic        cfg_ready, cfg_err, frame_sync, coeff_valid, ready_gate, frame_miss;
  logic [15:0] vin_xres, vin_yres, vout_xres, vout_yres;
  logic [31:0] scaler_width, scaler_height;

  video_scale_ctrl #(.DIV_W(32)) dut (
    .vin_clk      (clk),
    .rst_n        (rst_n),
    .frame_start  (frame_start),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_vin_xres (cvx),
    .cfg_vin_yres (cvy),
    .cfg_vout_xres(cox),
    .cfg_vout_yres(coy),
    .cfg_err      (cfg_err),
    .frame_sync   (frame_sync),
    .vin_xres     (vin_xres),
    .vin_yres     (vin_yres),
    .vout_xres    (vout_xres),
    .vout_yres    (vout_yres),
    .scaler_width (scaler_width),
    .scaler_height(scaler_height),
    .coeff_valid  (coeff_valid),
    .ready_gate   (ready_gate),
    .frame_miss   (frame_miss)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: applied outputs plus the one-deep pending slot.
  logic [15:0] m_vix = '0, m_viy = '0, m_vox = '0, m_voy = '0;
  logic [31:0] m_w = '0, m_h = '0;
  logic        m_cv = 1'b0;
  bit          m_pend = 1'b0;
  logic [15:0] s_vix, s_viy, s_vox, s_voy;

  typedef struct {
    logic [15:0] ix, iy, ox, oy;
    bit          err;
    int          lat;
    logic [15:0] eox;
    logic [31:0] ew, eh;
  } vec_t;
  vec_t tbl[5];

  function automatic logic [31:0] coef(input logic [15:0] vin, input logic [15:0] vout);
    logic [63:0] q;
    q = (64'(vin) * 64'd65536) / 64'(vout);
    return q[31:0] + 32'd1;
  endfunction

  function automatic logic [15:0] clampv(input logic [15:0] vout, input logic [15:0] vin);
`ifdef SCALE_CLAMP_EN
    return (vout > vin) ? vin : vout;
`else
    if (vin == 16'hFFFF) return vout;
    return vout;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, "_vin_x"}, 32'(vin_xres), 32'(m_vix));
    chk({tag, "_vin_y"}, 32'(vin_yres), 32'(m_viy));
    chk({tag, "_vout_x"}, 32'(vout_xres), 32'(m_vox));
    chk({tag, "_vout_y"}, 32'(vout_yres), 32'(m_voy));
    chk({tag, "_width"}, scaler_width, m_w);
    chk({tag, "_height"}, scaler_height, m_h);
    chk({tag, "_coeff_valid"}, 32'(coeff_valid), 32'(m_cv));
  endtask

  task automatic send_cfg(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d, output bit err);
    cvx = a; cvy = b; cox = c; coy = d;
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    err = cfg_err;
  endtask

  // Pulses frame_start in the current cycle; lat = cycles until frame_sync (-1 on timeout).
  task automatic run_frame(output int lat, output bit gate_low);
    frame_start = 1'b1;
    lat = -1;
    gate_low = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      frame_start = 1'b0;
      if (ready_gate) gate_low = 1'b0;
      if (frame_sync) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic post_frame(input string tag);
    @(posedge clk); #1;
    chk({tag, "_gate_after"}, 32'(ready_gate), 32'(m_cv));
    chk({tag, "_sync_one_cycle"}, 32'(frame_sync), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   e, gl, exp_err;
    int   lat, nsync, first;
    logic [15:0] ix, iy, ox, oy;

    tbl[0] = '{16'd1920, 16'd1080, 16'd960, 16'd540, 1'b0, 66, 16'd960, 32'h0002_0001, 32'h0002_0001};
    tbl[1] = '{16'd1920, 16'd1080, 16'd640, 16'd360, 1'b0, 66, 16'd640, 32'h0003_0001, 32'h0003_0001};
    tbl[2] = '{16'd1280, 16'd720, 16'd1280, 16'd720, 1'b0, 66, 16'd1280, 32'h0001_0001, 32'h0001_0001};
`ifdef SCALE_CLAMP_EN
    tbl[3] = '{16'd1920, 16'd1080, 16'd2560, 16'd1080, 1'b0, 66, 16'd1920, 32'h0001_0001, 32'h0001_0001};
`else
    tbl[3] = '{16'd1920, 16'd1080, 16'd2560, 16'd1080, 1'b0, 66, 16'd2560, 32'h0000_C001, 32'h0001_0001};
`endif
    tbl[4] = '{16'd1920, 16'd1080, 16'd960, 16'd0, 1'b1, 1, 16'd0, 32'h0, 32'h0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_outs("reset");
    chk("reset_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("reset_ready_gate", 32'(ready_gate), 32'd0);
    chk("reset_frame_sync", 32'(frame_sync), 32'd0);
    chk("reset_frame_miss", 32'(frame_miss), 32'd0);
    chk("reset_cfg_err", 32'(cfg_err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 5; k++) begin
      send_cfg(tbl[k].ix, tbl[k].iy, tbl[k].ox, tbl[k].oy, e);
      chk("tbl_cfg_err", 32'(e), 32'(tbl[k].err));
      chk("tbl_cfg_ready", 32'(cfg_ready), 32'(tbl[k].err));
      run_frame(lat, gl);
      chk("tbl_latency", 32'(lat), 32'(tbl[k].lat));
      chk("tbl_gate_low", 32'(gl), 32'd1);
      if (!tbl[k].err) begin
        m_vix = tbl[k].ix; m_viy = tbl[k].iy; m_vox = tbl[k].eox; m_voy = tbl[k].oy;
        m_w = tbl[k].ew; m_h = tbl[k].eh; m_cv = 1'b1;
      end
      chk_outs("tbl");
      post_frame("tbl");
    end

    // cfg_ready returns after LOAD; a config taken mid-division waits for the next frame.
    send_cfg(16'd1920, 16'd1080, 16'd960, 16'd540, e);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    chk("load_cfg_ready", 32'(cfg_ready), 32'd0);
    @(posedge clk); #1;
    chk("after_load_cfg_ready", 32'(cfg_ready), 32'd1);
    send_cfg(16'd1280, 16'd720, 16'd320, 16'd180, e);
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (frame_sync) begin lat = i; break; end
    end
    chk("middiv_sync_time", 32'(lat), 32'd63);
    m_vix = 16'd1920; m_viy = 16'd1080; m_vox = 16'd960; m_voy = 16'd540;
    m_w = 32'h0002_0001; m_h = 32'h0002_0001;
    chk_outs("middiv_first");
    chk("middiv_pending", 32'(cfg_ready), 32'd0);
    post_frame("middiv");
    run_frame(lat, gl);
    chk("middiv_next_latency", 32'(lat), 32'd66);
    m_vix = 16'd1280; m_viy = 16'd720; m_vox = 16'd320; m_voy = 16'd180;
    m_w = 32'h0004_0001; m_h = 32'h0004_0001;
    chk_outs("middiv_next");
    post_frame("middiv_next");

    // Simultaneous cfg_valid and frame_start with nothing pending
    cvx = 16'd1920; cvy = 16'd1080; cox = 16'd640; coy = 16'd360;
    cfg_valid = 1'b1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    frame_start = 1'b0;
    chk("simul_sync", 32'(frame_sync), 32'd1);
    chk("simul_pending", 32'(cfg_ready), 32'd0);
    chk_outs("simul");
    post_frame("simul");
    run_frame(lat, gl);
    chk("simul_next_latency", 32'(lat), 32'd66);
    m_vix = 16'd1920; m_viy = 16'd1080; m_vox = 16'd640; m_voy = 16'd360;
    m_w = 32'h0003_0001; m_h = 32'h0003_0001;
    chk_outs("simul_next");
    post_frame("simul_next");

    // frame_start during DIV_Y is dropped and flagged
    chk("miss_before", 32'(frame_miss), 32'd0);
    send_cfg(16'd1280, 16'd720, 16'd1280, 16'd720, e);
    frame_start = 1'b1;
    nsync = 0;
    first = -1;
    for (int i = 1; i <= 150; i++) begin
      @(posedge clk); #1;
      frame_start = (i == 40);
      if (frame_sync) begin
        nsync++;
        if (first < 0) first = i;
      end
    end
    chk("miss_sync_count", 32'(nsync), 32'd1);
    chk("miss_sync_time", 32'(first), 32'd66);
    chk("miss_flag", 32'(frame_miss), 32'd1);
    m_vix = 16'd1280; m_viy = 16'd720; m_vox = 16'd1280; m_voy = 16'd720;
    m_w = 32'h0001_0001; m_h = 32'h0001_0001;
    chk_outs("miss");

    // Reset in the middle of DIV_X
    send_cfg(16'd1920, 16'd1080, 16'd960, 16'd540, e);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    m_vix = '0; m_viy = '0; m_vox = '0; m_voy = '0; m_w = '0; m_h = '0; m_cv = 1'b0;
    chk_outs("rst_mid");
    chk("rst_mid_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_mid_frame_miss", 32'(frame_miss), 32'd0);
    chk("rst_mid_ready_gate", 32'(ready_gate), 32'd0);
    chk("rst_mid_frame_sync", 32'(frame_sync), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(lat, gl);
    chk("rst_mid_pending_lost", 32'(lat), 32'd1);
    chk_outs("rst_mid_after");
    post_frame("rst_mid");

    // Randomized frames against the model
    m_pend = 1'b0;
    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 2) != 0) begin
        ix = 16'($urandom_range(1, 65535));
        iy = 16'($urandom_range(1, 65535));
        ox = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
        oy = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
        send_cfg(ix, iy, ox, oy, e);
        exp_err = (ox == 16'd0) || (oy == 16'd0);
        chk("rnd_cfg_err", 32'(e), 32'(exp_err));
        if (!exp_err) begin
          s_vix = ix; s_viy = iy; s_vox = clampv(ox, ix); s_voy = clampv(oy, iy);
          m_pend = 1'b1;
        end
        chk("rnd_cfg_ready", 32'(cfg_ready), 32'(!m_pend));
      end
      run_frame(lat, gl);
      chk("rnd_latency", 32'(lat), m_pend ? 32'd66 : 32'd1);
      chk("rnd_gate_low", 32'(gl), 32'd1);
      if (m_pend) begin
        m_vix = s_vix; m_viy = s_viy; m_vox = s_vox; m_voy = s_voy;
        m_w = coef(s_vix, s_vox);
        m_h = coef(s_viy, s_voy);
        m_cv = 1'b1;
        m_pend = 1'b0;
      end
      chk_outs("rnd");
      post_frame("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/video_scale_ctrl.md
# video_scale_ctrl

Frame-level controller for the nearest-neighbour downscaler. It accepts a resolution configuration from the register/host side and holds it until the next source frame boundary. At that boundary it computes the 16.16 horizontal and vertical step coefficients with a shared serial divider, then issues the scaler's `frame_sync` pulse. While the coefficients are being computed it stalls the pixel stream through `ready_gate`.

## Interface
- `DIV_W`, 32: dividend/quotient width of the serial divider; the divisor is fixed at 16 bits.
- `vin_clk`  in  1  pixel/system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `frame_start`  in  1  one-cycle pulse at the start of each source frame.
- `cfg_valid`  in  1  configuration offered.
- `cfg_ready`  out  1  configuration slot free.
- `cfg_vin_xres`, `cfg_vin_yres`, `cfg_vout_xres`, `cfg_vout_yres`  in  16 each  requested resolutions.
- `cfg_err`  out  1  one-cycle pulse when a configuration is rejected.
- `frame_sync`  out  1  one-cycle pulse to the scaler.
- `vin_xres`, `vin_yres`, `vout_xres`, `vout_yres`  out  16 each  applied resolutions.
- `scaler_width`, `scaler_height`  out  32 each  applied 16.16 step coefficients.
- `coeff_valid`  out  1  high once the first configuration has been applied.
- `ready_gate`  out  1  the top level ANDs this with the downstream ready.
- `frame_miss`  out  1  sticky flag: a `frame_start` arrived while busy.

## Operation
- The configuration handshake is one-deep: a transfer occurs when `cfg_valid && cfg_ready`.
  - The accepted values go to a shadow register and a `pending` flag is set; `cfg_ready` = !`pending`.
- Rejection: any `cfg_vout_*` equal to 0 is rejected. `cfg_err` pulses the next cycle and nothing is stored.
- States:
  - IDLE → on `frame_start`: go to LOAD if `pending`, otherwise go to SYNC.
  - LOAD: copy shadow to working registers, clear `pending` → DIV_X.
  - DIV_X: compute `(vin_xres<<16)/vout_xres` by restoring division, 32 iterations (1 bit/cycle) → DIV_Y.
  - DIV_Y: same computation for y → SYNC.
  - SYNC: pulse `frame_sync`; update the resolution and coefficient outputs in the same cycle; set `coeff_valid` → IDLE.
- Coefficient = quotient + 1, truncated to 32 bits.
- `ready_gate` = 0 from LOAD through SYNC inclusive, and while `coeff_valid`=0. It is 1 otherwise.
- A `frame_start` in any state other than IDLE is ignored and sets `frame_miss`.
- A configuration may be accepted in any state. A configuration accepted during LOAD…SYNC takes effect at the following frame.

## Timing
- Reset values:
  - All outputs are 0 except `cfg_ready`=1.
  - `pending`=0; state=IDLE.
- Let `frame_start` occur at cycle T with a configuration pending:
  - LOAD at T+1.
  - DIV_X from T+2 to T+33.
  - DIV_Y from T+34 to T+65.
  - `frame_sync` and the new outputs appear at T+66.
- With no configuration pending, `frame_sync` appears at T+1 and the outputs are unchanged.
- `cfg_ready` returns to 1 in the cycle after LOAD.
- Simultaneous `cfg_valid` and `frame_start` in IDLE with `pending`=0: the new configuration does not apply to this frame. This frame takes the SYNC path and the configuration becomes pending.
- Reset asserted mid-division: everything returns to reset values immediately. Any pending configuration is lost.

## Configuration
- `SCALE_CLAMP_EN` defined: at acceptance, any `cfg_vout_*` greater than the matching `cfg_vin_*` is clamped to the `cfg_vin_*` value, which limits the block to downscale or 1:1.
- `SCALE_CLAMP_EN` not defined: values are stored unmodified, so a coefficient below 0x0001_0000 can result (upscale request, behaviour owned by the scaler).

## Structure
- Package `video_scale_pkg`:
  - state enum `vsc_state_t`.
  - `FRAC_BITS`=16.
  - `RES_W`=16.
- Sub-module `serial_div_u32_u16`:
  - start/done handshake, 32-cycle restoring divider.
  - One instance is time-shared between DIV_X and DIV_Y.

## Test plan
- Configure 1920×1080→960×540, then send `frame_start` at T → `frame_sync` at T+66; `scaler_width`=`scaler_height`=0x0002_0001; `ready_gate` low from T+1 to T+66.
- Configure 1920×1080→640×360 → `scaler_width`=`scaler_height`=0x0003_0001. A second `frame_start` with no new configuration → `frame_sync` at T+1 with unchanged outputs.
- Configure 1280×720→1280×720 → both coefficients 0x0001_0001.
- Configure `vout_xres`=2560 with `vin_xres`=1920:
  - `SCALE_CLAMP_EN` defined → `vout_xres`=1920, coefficient 0x0001_0001.
  - `SCALE_CLAMP_EN` not defined → coefficient 0x0000_C001.
- Configure `vout_yres`=0 → `cfg_err` pulse; `cfg_ready` stays 1; outputs unchanged.
- Send `frame_start` during DIV_Y → `frame_miss`=1 and no extra `frame_sync`. Assert `rst_n`=0 mid-DIV_X → all outputs at reset values on the same edge.
